// File: rtl/mult_div_unit.sv
// Iterative multiply/divide execute stage with private HI/LO registers.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator; fixed 34-cycle latency.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      count;
  logic               is_div;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;

  logic               open_window;
  logic               accept;
  logic               last_iter;
  logic               in_signed;
  logic               in_sign_a;
  logic               in_sign_b;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic [WIDTH-1:0]   raw_a;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // A new op or an MTHI/MTLO write is only taken while nothing is in flight.
  assign open_window = (state == IDLE) || (state == DONE);
  assign accept      = start && open_window;
  assign last_iter   = (count == CW'(WIDTH - 1));
  assign busy        = (state == CALC) || (state == FIX);
  assign done        = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Signed ops (op[0]==0) iterate on magnitudes; the signs are reapplied in FIX.
  always_comb begin
    in_signed = ~op[0];
    in_sign_a = in_signed & operand_a[WIDTH-1];
    in_sign_b = in_signed & operand_b[WIDTH-1];
    in_mag_a  = in_sign_a ? -operand_a : operand_a;
    in_mag_b  = in_sign_b ? -operand_b : operand_b;
  end

  // Multiply keeps the multiplier in acc's low half and shifts the product in from the top;
  // divide keeps the partial remainder high and shifts quotient bits in at the bottom.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
    mul_step  = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                       : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mag_b});
    div_diff  = div_shift[WIDTH-1:0] - mag_b;
    div_step  = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    prod_fixed = (sign_a ^ sign_b) ? -acc : acc;
    quot_fixed = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fixed  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    raw_a      = sign_a ? -mag_a : mag_a;
    fix_hi     = prod_fixed[2*WIDTH-1:WIDTH];
    fix_lo     = prod_fixed[WIDTH-1:0];
    if (is_div) begin
      if (div_by_zero) begin
        fix_hi = raw_a;
        fix_lo = '1;
      end else begin
        fix_hi = rem_fixed;
        fix_lo = quot_fixed;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      acc         <= '0;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      count       <= '0;
      is_div      <= op[1];
      sign_a      <= in_sign_a;
      sign_b      <= in_sign_b;
      mag_a       <= in_mag_a;
      mag_b       <= in_mag_b;
      acc         <= {{WIDTH{1'b0}}, (op[1] ? in_mag_a : in_mag_b)};
      div_by_zero <= op[1] && (operand_b == '0);
    end else if (state == CALC) begin
      count <= count + CW'(1);
      acc   <= is_div ? div_step : mul_step;
    end
  end

  // The FIX-edge result write wins; MT writes are only legal while idle or done.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else if (open_window) begin
      if (hi_we) hi <= hilo_wdata;
      if (lo_we) lo <= hilo_wdata;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a cycle-level reference model checked every cycle,
// plus hand-computed literal results for each directed vector.
module tb_mult_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hilo_wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total  = 0;

  int          ph = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [31:0] pend_hi = '0;
  logic [31:0] pend_lo = '0;
  logic        exp_dz = 1'b0;
  bit          model_valid = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .hilo_wdata (hilo_wdata),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    else
      passed++;
  endtask

  // Architectural result of each operation, straight from integer arithmetic.
  function automatic void model_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] h, output logic [31:0] l);
    longint      ps;
    logic [63:0] pu;
    int          sa;
    int          sb;
    int          q;
    int          r;
    h = '0;
    l = '0;
    case (o)
      OP_MULT: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        pu = ps;
        h  = pu[63:32];
        l  = pu[31:0];
      end
      OP_MULTU: begin
        pu = {32'b0, a} * {32'b0, b};
        h  = pu[63:32];
        l  = pu[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFF_FFFF;
        end else if (o == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 32'd0;
          l = 32'h8000_0000;
        end else if (o == OP_DIV) begin
          sa = a;
          sb = b;
          q  = sa / sb;
          r  = sa % sb;
          h  = r;
          l  = q;
        end else begin
          h = a % b;
          l = a / b;
        end
      end
    endcase
  endfunction

  // Reference timeline: ph counts cycles since the accepting edge; 1..33 busy, 34 done.
  always @(posedge clk) begin
    bit window;
    if (reset) begin
      ph          = 0;
      exp_hi      = '0;
      exp_lo      = '0;
      exp_dz      = 1'b0;
      model_valid = 1'b1;
    end else begin
      window = (ph == 0) || (ph == 34);
      if (ph == 33) begin
        exp_hi = pend_hi;
        exp_lo = pend_lo;
      end
      if (window && hi_we) exp_hi = hilo_wdata;
      if (window && lo_we) exp_lo = hilo_wdata;
      if (window && start) begin
        model_result(op, operand_a, operand_b, pend_hi, pend_lo);
        exp_dz = op[1] && (operand_b == 32'd0);
        ph = 1;
      end else if (ph == 34) begin
        ph = 0;
      end else if (ph != 0) begin
        ph++;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model_busy", busy, (ph >= 1 && ph <= 33));
      checkOutput("model_done", done, (ph == 34));
      checkOutput("model_div_by_zero", div_by_zero, exp_dz);
      checkOutput("model_hi", hi, exp_hi);
      checkOutput("model_lo", lo, exp_lo);
    end
  end

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) checkOutput("done_timeout", done, 1'b1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cycles);
    applyStimulus(o, a, b);
    wait_done(lat, busy_cycles);
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] l;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int bc;
    int done_count;

    vecs[0] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[1] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[3] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[4] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[5] = '{OP_MULTU, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[7] = '{OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};

    reset = 1'b1;
    start = 1'b0;
    op = 2'b00;
    operand_a = '0;
    operand_b = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    hilo_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_dz", div_by_zero, 1'b0);
    checkOutput("reset_hi", hi, 32'h0);
    checkOutput("reset_lo", lo, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    checkOutput("multu_latency", lat, 34);
    checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", lo, 32'h0000_0001);

    @(posedge clk);
    #1;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, lat, bc);
    checkOutput("mult_busy_cycles", bc, 33);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFF1);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat, bc);
    checkOutput("div_b2b_latency", lat, 34);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);

    @(posedge clk);
    #1;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    checkOutput("div_ovf_lo", lo, 32'h8000_0000);
    checkOutput("div_ovf_hi", hi, 32'h0000_0000);

    run_op(OP_DIVU, 32'd100, 32'd0, lat, bc);
    checkOutput("dbz_lo", lo, 32'hFFFF_FFFF);
    checkOutput("dbz_hi", hi, 32'h0000_0064);
    checkOutput("dbz_flag", div_by_zero, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("dbz_sticky", div_by_zero, 1'b1);

    lo_we = 1'b1;
    hilo_wdata = 32'h0000_AAAA;
    applyStimulus(OP_MULTU, 32'd2, 32'd3);
    @(negedge clk);
    checkOutput("mt_with_start_lo", lo, 32'h0000_AAAA);
    checkOutput("dbz_cleared", div_by_zero, 1'b0);
    wait_done(lat, bc);
    checkOutput("multu23_lo", lo, 32'h0000_0006);
    checkOutput("multu23_hi", hi, 32'h0000_0000);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      run_op(vecs[i].o, vecs[i].a, vecs[i].b, lat, bc);
      checkOutput($sformatf("vec%0d_hi", i), hi, vecs[i].h);
      checkOutput($sformatf("vec%0d_lo", i), lo, vecs[i].l);
    end

    @(posedge clk);
    #1;
    applyStimulus(OP_MULTU, 32'd7, 32'd9);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    op = OP_DIVU;
    operand_a = 32'd100;
    operand_b = 32'd0;
    hi_we = 1'b1;
    hilo_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    wait_done(lat, bc);
    checkOutput("ignored_lo", lo, 32'h0000_003F);
    checkOutput("ignored_hi", hi, 32'h0000_0000);
    checkOutput("ignored_dz", div_by_zero, 1'b0);

    @(posedge clk);
    #1;
    hi_we = 1'b1;
    hilo_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    @(negedge clk);
    checkOutput("mthi_hi", hi, 32'h1234_5678);
    checkOutput("mthi_lo_kept", lo, 32'h0000_003F);
    @(posedge clk);
    #1;
    hi_we = 1'b1;
    lo_we = 1'b1;
    hilo_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    @(negedge clk);
    checkOutput("mt_both_hi", hi, 32'hCAFE_F00D);
    checkOutput("mt_both_lo", lo, 32'hCAFE_F00D);

    @(posedge clk);
    #1;
    applyStimulus(OP_MULTU, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_hi", hi, 32'h0);
    checkOutput("abort_lo", lo, 32'h0);
    done_count = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_count++;
    end
    checkOutput("abort_no_done", done_count, 0);

    @(posedge clk);
    #1;
    run_op(OP_MULTU, 32'd3, 32'd4, lat, bc);
    checkOutput("b2b_first_lo", lo, 32'h0000_000C);
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bc);
    checkOutput("b2b_second_latency", lat, 34);
    checkOutput("b2b_second_lo", lo, 32'h0000_000E);
    checkOutput("b2b_second_hi", hi, 32'h0000_0002);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
